// File: rtl/elevator_ctrl.sv
// Dispatch FSM for a 4-storey elevator: latches car/hall calls, tracks floor and direction,
// and commands the run timer (mv2nxt) and door timer (opendoor) from their done-flag rises.
module elevator_ctrl #(
    parameter logic [1:0] RESET_FLOOR = 2'd0
) (
    input  logic       CP,
    input  logic       CR,
    input  logic [3:0] car_btn,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
    input  logic       endRun,
    input  logic       endOpen,
    output logic       mv2nxt,
    output logic       opendoor,
    output logic [1:0] floor,
    output logic [1:0] dir,
    output logic [3:0] car_req,
    output logic [3:0] up_req,
    output logic [3:0] dn_req
);
    typedef enum logic [1:0] {IDLE, RUN, DECIDE, OPEN} state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    state_t     state, state_nxt;
    logic [1:0] floor_nxt, dir_nxt, rev_dir;
    logic [3:0] car_clr, up_clr, dn_clr;
    logic [3:0] pend, sel, below_mask, above_mask;
    logic       endrun_q, endopen_q, run_rise, open_rise;
    logic       here, above, below, ahead, behind, same_hall, stop;

    assign run_rise  = endRun  & ~endrun_q;
    assign open_rise = endOpen & ~endopen_q;

    assign pend       = car_req | up_req | dn_req;
    assign sel        = 4'b0001 << floor;
    assign below_mask = sel - 4'd1;
    assign above_mask = ~(sel | below_mask);

    assign here  = |(pend & sel);
    assign above = |(pend & above_mask);
    assign below = |(pend & below_mask);

    // With no travel direction everything off-floor counts as "behind".
    assign ahead     = (dir == DIR_UP) ? above : (dir == DIR_DN) ? below : 1'b0;
    assign behind    = (dir == DIR_UP) ? below : (dir == DIR_DN) ? above : (above | below);
    assign rev_dir   = (dir == DIR_UP) ? DIR_DN : (dir == DIR_DN) ? DIR_UP :
                       (above ? DIR_UP : DIR_DN);
    assign same_hall = (dir == DIR_UP) ? |(up_req & sel) :
                       (dir == DIR_DN) ? |(dn_req & sel) : 1'b0;
    assign stop      = |(car_req & sel) | same_hall | (~ahead & here);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_nxt = state;
        floor_nxt = floor;
        dir_nxt   = dir;
        car_clr   = 4'b0000;
        up_clr    = 4'b0000;
        dn_clr    = 4'b0000;
        unique case (state)
            IDLE: begin
                if (here) begin
                    state_nxt = OPEN;
                    car_clr   = sel;
                    up_clr    = sel;
                    dn_clr    = sel;
                end else if (above) begin
                    dir_nxt   = DIR_UP;
                    state_nxt = RUN;
                end else if (below) begin
                    dir_nxt   = DIR_DN;
                    state_nxt = RUN;
                end else begin
                    dir_nxt   = DIR_IDLE;
                end
            end
            RUN: begin
                if (run_rise) begin
                    if (dir == DIR_UP && floor != 2'd3)
                        floor_nxt = floor + 2'd1;
                    else if (dir == DIR_DN && floor != 2'd0)
                        floor_nxt = floor - 2'd1;
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (stop) begin
                    car_clr   = sel;
                    up_clr    = (dir == DIR_UP) ? sel : 4'b0000;
                    dn_clr    = (dir == DIR_DN) ? sel : 4'b0000;
                    state_nxt = OPEN;
                    if (!ahead) begin
                        up_clr  = sel;
                        dn_clr  = sel;
                        dir_nxt = behind ? rev_dir : DIR_IDLE;
                    end
                end else if (ahead) begin
                    state_nxt = RUN;
                end else if (behind) begin
                    dir_nxt   = rev_dir;
                    state_nxt = RUN;
                end else begin
                    dir_nxt   = DIR_IDLE;
                    state_nxt = IDLE;
                end
            end
            OPEN: begin
                // Door open: anything pressed at this floor is served immediately.
                car_clr = sel;
                up_clr  = sel;
                dn_clr  = sel;
                if (open_rise)
                    state_nxt = DECIDE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state     <= IDLE;
            floor     <= RESET_FLOOR;
            dir       <= DIR_IDLE;
            mv2nxt    <= 1'b0;
            opendoor  <= 1'b0;
            car_req   <= 4'b0000;
            up_req    <= 4'b0000;
            dn_req    <= 4'b0000;
            endrun_q  <= 1'b0;
            endopen_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            state     <= state_nxt;
            floor     <= floor_nxt;
            dir       <= dir_nxt;
            mv2nxt    <= (state_nxt == RUN);
            opendoor  <= (state_nxt == OPEN);
            car_req   <= (car_req | car_btn) & ~car_clr;
            up_req    <= (up_req  | hall_up) & ~up_clr & 4'b0111;
            dn_req    <= (dn_req  | hall_dn) & ~dn_clr & 4'b1110;
            endrun_q  <= endRun;
            endopen_q <= endOpen;
        end
    end
endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Main dispatch FSM of the 4-storey elevator controller, sitting directly upstream of the run timer, the door timer and the clock divider.
- Latches car and hall calls and keeps the current floor and travel direction.
- Drives the move-to-next-floor command (mv2nxt) and the open-door command (opendoor).
- Consumes endRun and endOpen from the timers to advance one floor or to close the door.

Parameters:
- RESET_FLOOR, 2'd0: floor index loaded on reset (0 = ground, 3 = top).

Ports:
- CP  input  1  system clock, the 32 Hz clk32hz; all state updates on posedge CP.
- CR  input  1  asynchronous, active-high reset.
- car_btn  input  4  car call buttons, one bit per floor, level, active-high.
- hall_up  input  4  hall up buttons; bit 3 is ignored (no up call at the top floor).
- hall_dn  input  4  hall down buttons; bit 0 is ignored (no down call at the ground floor).
- endRun  input  1  run-timer done flag (level).
- endOpen  input  1  door-timer done flag (level).
- mv2nxt  output  1  StRun command to the run timer and the divider.
- opendoor  output  1  StOpen command to the door timer and the divider.
- floor  output  2  current floor index.
- dir  output  2  travel direction: 00 idle, 01 up, 10 down; 11 is never driven.
- car_req  output  4  pending car calls (lamps).
- up_req  output  4  pending up calls; bit 3 is always 0.
- dn_req  output  4  pending down calls; bit 0 is always 0.

Behaviour:
- Reset (CR=1), asynchronous and immediate:
  - state=IDLE, floor=RESET_FLOOR, dir=00.
  - mv2nxt=0, opendoor=0.
  - all request registers are 0; the edge-detect registers are cleared to 0.
- Reset applies mid-RUN or mid-OPEN with the same effect; no partial move is committed.
- Request latching, every cycle:
  - req |= button.
  - A clear from the serving logic in the same cycle overrides the set at the served floor/direction.
  - A button held at a floor that is being served does not re-latch while the state is OPEN.
- Edge detection:
  - endRun and endOpen are registered each cycle; a "rise" is current=1 and previous=0.
  - FSM transitions use rises only, because the timer flags may stay high one or more cycles after the command drops.
- Definitions:
  - here = any request bit at floor.
  - above = any request at a floor greater than floor.
  - below = any request at a floor less than floor.
- States. mv2nxt=1 only in RUN; opendoor=1 only in OPEN; both outputs are registered Moore outputs.
- IDLE:
  - If here: go to OPEN and clear car_req, up_req and dn_req at floor.
  - Else if above: dir=01, go to RUN.
  - Else if below: dir=10, go to RUN.
  - Else stay; dir=00.
  - Priority is here > above > below.
- RUN:
  - Hold mv2nxt=1.
  - On an endRun rise: floor increments (dir=01) or decrements (dir=10), then go to DECIDE.
  - Otherwise hold.
- DECIDE: one cycle, both commands 0. Evaluated at the new floor:
  - Stop if car_req[floor], or a same-direction hall call at floor, or (no calls ahead and here).
  - On stop, clear car_req[floor] and the same-direction hall call, then go to OPEN.
  - When there are no calls ahead, also clear the opposite hall call and set dir to the reversed direction, or 00 if nothing is pending.
  - Not stopping and calls ahead: go to RUN, dir unchanged.
  - Not stopping, none ahead, calls behind: reverse dir, go to RUN.
  - Nothing pending: dir=00, go to IDLE.
- OPEN:
  - Hold opendoor=1.
  - Calls at the current floor are cleared as they arrive.
  - On an endOpen rise: go to DECIDE (re-evaluates from the same floor; nothing is left to stop for here) and then to RUN or IDLE.
- Boundaries:
  - Floor is never incremented at 3 nor decremented at 0, because the "ahead" sets are empty there.
  - An endRun rise outside RUN, or an endOpen rise outside OPEN, is ignored.
- Simultaneous events:
  - A button press at the floor being stopped at in DECIDE is cleared in that same cycle.
  - Presses at other floors latch normally in every state.

Test Plan:
- Reset at floor 0, pulse car_btn=4'b1000 -> IDLE->RUN, dir=01, mv2nxt=1. Three endRun rises -> floor 1, 2, 3. DECIDE at 3 -> OPEN, car_req=0. After an endOpen rise -> IDLE, dir=00.
- Start at floor 0 with a pending car call at 3. Press hall_dn[1] while moving up -> no stop at floor 1 (wrong direction), serve 3, reverse, stop at 1 with dn_req[1] cleared.
- At floor 2 idle, press car_btn[2] -> OPEN within 2 cycles, mv2nxt stays 0, car_req[2] is never visible after the next cycle.
- Hold endRun high for 8 cycles across DECIDE->RUN -> exactly one floor step, confirming edge detection.
- Assert CR mid-RUN at floor 1 with car_req=4'b1100 -> outputs immediately 0, floor=RESET_FLOOR, all requests 0.
- Press hall_up[3] and hall_dn[0] -> up_req[3] and dn_req[0] stay 0, FSM stays IDLE.
